// File: rtl/nes_clk_pkg.sv
// Shared NES clocking types and constants: sequencer state encoding and default divider ratios.
// No latency or backpressure: this package holds declarations only.
package nes_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } seq_state_t;

    localparam int NES_MASTER_HZ = 21477272;
    localparam int NES_CPU_DIV   = 12;
    localparam int NES_PPU_DIV   = 4;
    localparam int RELOCK_CNT_W  = 8;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with synchronous reset to 0.
// Output follows the input after 2 clk edges; there is no backpressure.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nes_clock_sequencer.sv
// Holds the NES core in reset until PLL lock is stable, then emits PPU/CPU clock enables from one divider.
// RUN starts LOCK_HOLD_CYCLES+1 cycles after synchronised lock; all outputs registered, no backpressure.
module nes_clock_sequencer
    import nes_clk_pkg::*;
#(
    parameter int LOCK_HOLD_CYCLES = 1024,
    parameter int CPU_DIV          = NES_CPU_DIV,
    parameter int PPU_DIV          = NES_PPU_DIV,
    parameter int CPU_PHASE        = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pll_locked,
    output logic                    sys_rst,
    output logic                    ppu_ce,
    output logic                    cpu_ce,
    output logic                    running,
    output logic [RELOCK_CNT_W-1:0] relock_count
);

    generate
        if (LOCK_HOLD_CYCLES < 1 || PPU_DIV < 2 || CPU_DIV < PPU_DIV ||
            (CPU_DIV % PPU_DIV) != 0 || CPU_PHASE < 0 || CPU_PHASE >= CPU_DIV) begin : g_bad_params
            $error("nes_clock_sequencer: illegal parameter combination");
        end
    endgenerate

    localparam int HOLD_W = clog2_min1(LOCK_HOLD_CYCLES);
    // One extra bit so PPU_DIV itself fits when it equals CPU_DIV.
    localparam int DIV_W  = clog2_min1(CPU_DIV + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CPU_DIV - 1);
    localparam logic [DIV_W-1:0]  PPU_D     = DIV_W'(PPU_DIV);
    localparam logic [DIV_W-1:0]  PHASE     = DIV_W'(CPU_PHASE);

    seq_state_t              state_q;
    logic [HOLD_W-1:0]       hold_cnt_q;
    logic [DIV_W-1:0]        div_cnt_q;
    logic [DIV_W-1:0]        div_cnt_d;
    logic                    sys_rst_q;
    logic                    ppu_ce_q;
    logic                    cpu_ce_q;
    logic                    running_q;
    logic [RELOCK_CNT_W-1:0] relock_q;
    logic                    locked_s;

    sync_2ff u_lock_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    assign div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_LOCK;
            hold_cnt_q <= '0;
            div_cnt_q  <= '0;
            sys_rst_q  <= 1'b1;
            ppu_ce_q   <= 1'b0;
            cpu_ce_q   <= 1'b0;
            running_q  <= 1'b0;
            relock_q   <= '0;
        end else begin
            ppu_ce_q <= 1'b0;
            cpu_ce_q <= 1'b0;
            case (state_q)
                WAIT_LOCK: begin
                    hold_cnt_q <= '0;
                    sys_rst_q  <= 1'b1;
                    running_q  <= 1'b0;
                    if (locked_s) begin
                        state_q <= STABILIZE;
                    end
                end
                STABILIZE: begin
                    if (!locked_s) begin
                        state_q    <= WAIT_LOCK;
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        // Entering RUN: the first RUN cycle already carries div_cnt = 0 enables.
                        state_q    <= RUN;
                        hold_cnt_q <= '0;
                        div_cnt_q  <= '0;
                        sys_rst_q  <= 1'b0;
                        running_q  <= 1'b1;
                        ppu_ce_q   <= 1'b1;
                        cpu_ce_q   <= (PHASE == '0);
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_q   <= WAIT_LOCK;
                        sys_rst_q <= 1'b1;
                        running_q <= 1'b0;
                        if (relock_q != '1) begin
                            relock_q <= relock_q + 1'b1;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_d;
                        ppu_ce_q  <= ((div_cnt_d % PPU_D) == '0);
                        cpu_ce_q  <= (div_cnt_d == PHASE);
                    end
                end
                default: begin
                    state_q <= WAIT_LOCK;
                end
            endcase
        end
    end

    assign sys_rst      = sys_rst_q;
    assign ppu_ce       = ppu_ce_q;
    assign cpu_ce       = cpu_ce_q;
    assign running      = running_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_nes_clock_sequencer.sv
// Directed bench for nes_clock_sequencer: two instances (CPU_PHASE 0 and 5) share clock, reset and lock input.
module tb_nes_clock_sequencer;

    localparam int BIG = 1 << 30;

    logic       clk;
    logic       rst;
    logic       pll_locked;

    logic       sys_rst0, ppu_ce0, cpu_ce0, running0;
    logic [7:0] relock0;
    logic       sys_rst5, ppu_ce5, cpu_ce5, running5;
    logic [7:0] relock5;

    int tests;
    int fails;
    int cyc;
    int ppu_n, cpu0_n, cpu5_n;
    logic prev_ppu0, prev_cpu0, prev_cpu5;

    nes_clock_sequencer #(
        .LOCK_HOLD_CYCLES (16),
        .CPU_DIV          (12),
        .PPU_DIV          (4),
        .CPU_PHASE        (0)
    ) dut0 (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .sys_rst      (sys_rst0),
        .ppu_ce       (ppu_ce0),
        .cpu_ce       (cpu_ce0),
        .running      (running0),
        .relock_count (relock0)
    );

    nes_clock_sequencer #(
        .LOCK_HOLD_CYCLES (16),
        .CPU_DIV          (12),
        .PPU_DIV          (4),
        .CPU_PHASE        (5)
    ) dut5 (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .sys_rst      (sys_rst5),
        .ppu_ce       (ppu_ce5),
        .cpu_ce       (cpu_ce5),
        .running      (running5),
        .relock_count (relock5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        prev_ppu0 = ppu_ce0;
        prev_cpu0 = cpu_ce0;
        prev_cpu5 = cpu_ce5;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // RUN expected in [t0, toff); enables are phased from t0.
    task automatic check_cycle(input int t0, input int toff);
        bit run;
        int d;
        run = (cyc >= t0) && (cyc < toff);
        d   = cyc - t0;
        chk("sys_rst0", sys_rst0, !run);
        chk("running0", running0, run);
        chk("sys_rst5", sys_rst5, !run);
        chk("running5", running5, run);
        chk("ppu_ce0", ppu_ce0, run && (d % 4 == 0));
        chk("ppu_ce5", ppu_ce5, run && (d % 4 == 0));
        chk("cpu_ce0", cpu_ce0, run && (d % 12 == 0));
        chk("cpu_ce5", cpu_ce5, run && (d % 12 == 5));
        chk("ppu_consec", ppu_ce0 && prev_ppu0, 0);
        chk("cpu_consec", (cpu_ce0 && prev_cpu0) || (cpu_ce5 && prev_cpu5), 0);
        if (ppu_ce0) ppu_n++;
        if (cpu_ce0) cpu0_n++;
        if (cpu_ce5) cpu5_n++;
    endtask

    task automatic run_to(input int target, input int t0, input int toff);
        while (cyc < target) begin
            check_cycle(t0, toff);
            step();
        end
    endtask

    initial begin
        int t0;
        int r;
        tests = 0;
        fails = 0;
        cyc = 0;
        ppu_n = 0;
        cpu0_n = 0;
        cpu5_n = 0;
        prev_ppu0 = 1'b0;
        prev_cpu0 = 1'b0;
        prev_cpu5 = 1'b0;
        rst = 1'b1;
        pll_locked = 1'b0;
        @(negedge clk);
        repeat (3) step();

        chk("rst_sys_rst", sys_rst0, 1);
        chk("rst_running", running0, 0);
        chk("rst_ppu_ce", ppu_ce0, 0);
        chk("rst_cpu_ce", cpu_ce0, 0);
        chk("rst_relock", relock0, 0);

        // Clean lock: pll already high when reset releases, T0 = 19.
        pll_locked = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        run_to(69, 19, BIG);

        // Lock loss at RUN+50 for 5 cycles: outputs off at 72, relock T0 = 76 + 17 = 93.
        pll_locked = 1'b0;
        run_to(74, 19, 72);
        pll_locked = 1'b1;
        chk("relock_after_loss", relock0, 1);
        chk("relock_after_loss5", relock5, 1);
        run_to(93, 93, BIG);

        ppu_n = 0;
        cpu0_n = 0;
        cpu5_n = 0;
        run_to(1293, 93, BIG);
        chk("ppu_count_1200", ppu_n, 300);
        chk("cpu0_count_1200", cpu0_n, 100);
        chk("cpu5_count_1200", cpu5_n, 100);

        // One-cycle drops from RUN, each re-locks 20 cycles later; counter must stick at 255.
        for (int i = 2; i <= 260; i++) begin
            pll_locked = 1'b0;
            step();
            pll_locked = 1'b1;
            repeat (24) step();
            chk("sat_running", running0, 1);
            chk("sat_relock", relock0, (i > 255) ? 255 : i);
        end

        // Reset one cycle at RUN+7; with lock held, RUN returns 19 cycles after reset.
        t0 = cyc - 5;
        run_to(t0 + 7, t0, BIG);
        check_cycle(t0, BIG);
        r = cyc;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrun_rst_relock0", relock0, 0);
        chk("midrun_rst_relock5", relock5, 0);
        run_to(r + 50, r + 20, BIG);

        // Glitch in STABILIZE after 10 locked cycles: hold restarts, T0 moves from 19 to 30.
        rst = 1'b1;
        pll_locked = 1'b0;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        pll_locked = 1'b1;
        run_to(10, 30, BIG);
        pll_locked = 1'b0;
        run_to(11, 30, BIG);
        pll_locked = 1'b1;
        run_to(60, 30, BIG);
        chk("glitch_relock", relock0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
